// File: rtl/lsu_stage.sv
// Memory-stage load/store unit: turns one execute request into a word-aligned req/gnt/rvalid
// transaction and returns extended load data. Optional counters under LSU_PERF_CNT_EN.
module lsu_stage #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter logic [31:0] DMEM_BASE = 32'h0200_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misalign_o,
  output logic              busy_o,
  output logic [31:0]       perf_loads_o,
  output logic [31:0]       perf_stores_o,
  output logic [31:0]       perf_stall_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  state_e state_q, state_d;

  logic [AWIDTH-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [4:0]        rd_q;
  logic              is_store_q;
  logic              misalign_q;
  logic [DWIDTH-1:0] wb_data_q;
  logic [4:0]        wb_rd_q;

  logic              accept;
  logic              misalign_in;
  logic              load_capture;
  logic [3:0]        be_lane;
  logic [DWIDTH-1:0] wdata_lane;
  logic [DWIDTH-1:0] rdata_shifted;
  logic [DWIDTH-1:0] load_ext;

  // addr_i is already absolute, so the base address only documents the memory map
  logic unused_base;
  assign unused_base = ^DMEM_BASE;

  assign accept = req_valid_i && (state_q == StIdle);
  assign misalign_in = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       (funct3_i[1] && (addr_i[1:0] != 2'b00));
  assign load_capture = !is_store_q && mem_rvalid_i &&
                        (((state_q == StReq) && mem_gnt_i) || (state_q == StWaitR));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !misalign_in) state_d = StReq;
      end
      StReq: begin
        if (mem_gnt_i) begin
          if (is_store_q)        state_d = StIdle;
          else if (mem_rvalid_i) state_d = StResp;
          else                   state_d = StWaitR;
        end
      end
      StWaitR: begin
        if (mem_rvalid_i) state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    mem_req_o   = (state_q == StReq);
    mem_we_o    = (state_q == StReq) && is_store_q;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (state_q == StReq) begin
      mem_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
      mem_be_o    = be_lane;
      mem_wdata_o = wdata_lane;
    end
    wb_valid_o  = (state_q == StResp);
    wb_rd_o     = wb_rd_q;
    wb_data_o   = wb_data_q;
    misalign_o  = misalign_q;
  end

  // Byte lanes; funct3 2'b11 is treated as a word access
  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = wdata_q;
    if (funct3_q[1:0] == 2'b00) begin
      be_lane    = 4'b0001 << addr_q[1:0];
      wdata_lane = {4{wdata_q[7:0]}};
    end else if (funct3_q[1:0] == 2'b01) begin
      be_lane    = 4'b0011 << {addr_q[1], 1'b0};
      wdata_lane = {2{wdata_q[15:0]}};
    end
  end

  assign rdata_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    if (funct3_q[1:0] == 2'b00) begin
      load_ext = funct3_q[2] ? {24'b0, rdata_shifted[7:0]}
                             : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
    end else if (funct3_q[1:0] == 2'b01) begin
      load_ext = funct3_q[2] ? {16'b0, rdata_shifted[15:0]}
                             : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      is_store_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      if (accept) begin
        addr_q     <= addr_i;
        funct3_q   <= funct3_i;
        wdata_q    <= wdata_i;
        rd_q       <= rd_i;
        is_store_q <= is_store_i;
      end
      misalign_q <= accept && misalign_in;
      if (load_capture) begin
        wb_data_q <= load_ext;
        wb_rd_q   <= rd_q;
      end
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (state_q == StResp) perf_loads_q <= perf_loads_q + 32'd1;
      if ((state_q == StReq) && mem_gnt_i && is_store_q) perf_stores_q <= perf_stores_q + 32'd1;
      if (state_q != StIdle) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_loads_o  = perf_loads_q;
  assign perf_stores_o = perf_stores_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_loads_o  = '0;
  assign perf_stores_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: stores, loads, misalignment, same-cycle gnt/rvalid, reset abort
// and (with LSU_PERF_CNT_EN) the performance counters.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, mem_req, mem_we, wb_valid, misalign, busy;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;
  logic [31:0] perf_loads, perf_stores, perf_stall;

  int n_total = 0;
  int n_bad   = 0;

  int          req_cyc, busy_cyc, wb_cyc, unstable, stall_exp;
  logic [31:0] addr_s, wdata_s, wb_data_s;
  logic [3:0]  be_s;
  logic        we_s;
  logic [4:0]  wb_rd_s;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rd_i         (rd),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .misalign_o   (misalign),
    .busy_o       (busy),
    .perf_loads_o (perf_loads),
    .perf_stores_o(perf_stores),
    .perf_stall_o (perf_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r);
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; wdata = wd; rd = r; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Memory responder: grants after gnt_lat waiting request cycles, rvalid rv_lat cycles after gnt
  // (0 = same cycle). Records what the DUT drove and what came back.
  task automatic mem_txn(input int gnt_lat, input int rv_lat, input logic [31:0] rdata);
    int  k;
    int  since_gnt;
    bit  granted;
    bit  done;
    req_cyc = 0; busy_cyc = 0; wb_cyc = 0; unstable = 0;
    since_gnt = 0; granted = 1'b0; done = 1'b0;
    addr_s = '0; wdata_s = '0; be_s = '0; we_s = 1'b0; wb_data_s = '0; wb_rd_s = '0;
    for (k = 0; k < 40 && !done; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (granted && !busy) begin
        done = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (wb_valid) begin
          wb_cyc++; wb_data_s = wb_data; wb_rd_s = wb_rd;
        end
        if (mem_req) begin
          req_cyc++;
          if (req_cyc == 1) begin
            addr_s = mem_addr; wdata_s = mem_wdata; be_s = mem_be; we_s = mem_we;
          end else if (addr_s != mem_addr || wdata_s != mem_wdata || be_s != mem_be ||
                       we_s != mem_we) begin
            unstable++;
          end
          if (req_cyc == gnt_lat + 1) begin
            mem_gnt = 1'b1; granted = 1'b1;
            if (rv_lat == 0) begin
              mem_rvalid = 1'b1; mem_rdata = rdata;
            end
          end
        end else if (granted) begin
          since_gnt++;
          if (since_gnt == rv_lat) begin
            mem_rvalid = 1'b1; mem_rdata = rdata;
          end
        end
        @(negedge clk);
      end
    end
    check("txn_timeout", {31'b0, !done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0; rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b1;

    // sw with gnt after two waiting cycles
    issue(1'b1, 3'b010, 32'h0200_0008, 32'hDEAD_BEEF, 5'd0);
    mem_txn(2, 99, 32'h0);
    check("sw_req_cycles", req_cyc, 32'd3);
    check("sw_busy_cycles", busy_cyc, 32'd3);
    check("sw_no_wb", wb_cyc, 32'd0);
    check("sw_addr", addr_s, 32'h0200_0008);
    check("sw_be", {28'b0, be_s}, 32'hF);
    check("sw_we", {31'b0, we_s}, 32'd1);
    check("sw_wdata", wdata_s, 32'hDEAD_BEEF);
    check("sw_stable", unstable, 32'd0);

    // sb to the top byte lane
    issue(1'b1, 3'b000, 32'h0200_0013, 32'h0000_00A5, 5'd0);
    mem_txn(0, 99, 32'h0);
    check("sb_addr", addr_s, 32'h0200_0010);
    check("sb_be", {28'b0, be_s}, 32'h8);
    check("sb_wdata", wdata_s, 32'hA5A5_A5A5);

    // lb / lbu from byte 1
    issue(1'b0, 3'b000, 32'h0200_0001, 32'h0, 5'd5);
    mem_txn(0, 1, 32'h1234_8000);
    check("lb_data", wb_data_s, 32'hFFFF_FF80);
    check("lb_rd", {27'b0, wb_rd_s}, 32'd5);
    check("lb_wb_pulse", wb_cyc, 32'd1);
    check("lb_we", {31'b0, we_s}, 32'd0);
    check("lb_be", {28'b0, be_s}, 32'h2);
    check("lb_hold", wb_data, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h0200_0001, 32'h0, 5'd5);
    mem_txn(1, 2, 32'h1234_8000);
    check("lbu_data", wb_data_s, 32'h0000_0080);

    // lh from upper half
    issue(1'b0, 3'b001, 32'h0200_0002, 32'h0, 5'd7);
    mem_txn(0, 1, 32'h9ABC_0000);
    check("lh_data", wb_data_s, 32'hFFFF_9ABC);
    check("lh_be", {28'b0, be_s}, 32'hC);
    check("lh_rd", {27'b0, wb_rd_s}, 32'd7);

    // misaligned lw
    issue(1'b0, 3'b010, 32'h0200_0006, 32'h0, 5'd3);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_no_req", {31'b0, mem_req}, 32'd0);
    check("mis_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("mis_pulse_end", {31'b0, misalign}, 32'd0);
    check("mis_idle", {31'b0, busy}, 32'd0);

    // lw with gnt and rvalid together
    issue(1'b0, 3'b010, 32'h0200_0004, 32'h0, 5'd9);
    mem_txn(0, 0, 32'h0BAD_F00D);
    check("lw_same_data", wb_data_s, 32'h0BAD_F00D);
    check("lw_same_busy", busy_cyc, 32'd2);
    check("lw_same_pulse", wb_cyc, 32'd1);

    // sh, with a competing request offered while busy
    issue(1'b1, 3'b001, 32'h0200_0022, 32'h0000_1234, 5'd0);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0200_0100; req_valid = 1'b1;
    check("busy_not_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    mem_txn(0, 99, 32'h0);
    check("sh_addr", addr_s, 32'h0200_0020);
    check("sh_be", {28'b0, be_s}, 32'hC);
    check("sh_wdata", wdata_s, 32'h1234_1234);
    check("sh_we", {31'b0, we_s}, 32'd1);

    // reset while waiting for rvalid
    issue(1'b0, 3'b010, 32'h0200_0010, 32'h0, 5'd4);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("waitr_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_wb_data", wb_data, 32'd0);
    check("abort_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray_no_wb", {31'b0, wb_valid}, 32'd0);
    check("stray_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("stray_no_wb2", {31'b0, wb_valid}, 32'd0);
    check("stray_wb_data", wb_data, 32'd0);

    // 3 loads (one to x0) and 2 stores after reset
    stall_exp = 0;
    issue(1'b0, 3'b010, 32'h0200_0000, 32'h0, 5'd0);
    mem_txn(1, 1, 32'h5555_AAAA);
    stall_exp += busy_cyc;
    check("x0_pulse", wb_cyc, 32'd1);
    check("x0_rd", {27'b0, wb_rd_s}, 32'd0);
    check("x0_data", wb_data_s, 32'h5555_AAAA);
    issue(1'b1, 3'b010, 32'h0200_0040, 32'h1111_2222, 5'd0);
    mem_txn(0, 99, 32'h0);
    stall_exp += busy_cyc;
    issue(1'b0, 3'b101, 32'h0200_0042, 32'h0, 5'd12);
    mem_txn(0, 3, 32'h8001_7FFF);
    stall_exp += busy_cyc;
    check("lhu_data", wb_data_s, 32'h0000_8001);
    issue(1'b1, 3'b000, 32'h0200_0041, 32'h0000_0033, 5'd0);
    mem_txn(3, 99, 32'h0);
    stall_exp += busy_cyc;
    issue(1'b0, 3'b000, 32'h0200_0043, 32'h0, 5'd1);
    mem_txn(0, 0, 32'h7F00_0000);
    stall_exp += busy_cyc;
    check("lb_pos_data", wb_data_s, 32'h0000_007F);
`ifdef LSU_PERF_CNT_EN
    check("perf_loads", perf_loads, 32'd3);
    check("perf_stores", perf_stores, 32'd2);
    check("perf_stall", perf_stall, stall_exp);
`else
    check("perf_loads_off", perf_loads, 32'd0);
    check("perf_stores_off", perf_stores, 32'd0);
    check("perf_stall_off", perf_stall, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
